// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The CSUM state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
// No logic here; header length and word width are fixed constants.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM,
`endif
      ST_DONE,
      ST_ERR
   } state_t;

   localparam int HDR_BYTES      = 2;
   localparam int HDR_W          = HDR_BYTES * 8;
   localparam int BYTES_PER_WORD = 4;

   // A usable program has at least one word and fits the memory.
   function automatic logic hdr_ok(input logic [HDR_W-1:0] n, input int max_words);
      return (n != '0) && ({{(32-HDR_W){1'b0}}, n} <= 32'(max_words));
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Zero latency (wires only); byte_valid/byte_ready carries the backpressure.
// slave = loader side, master = byte source / memory side.
interface imem_loader_if #(
   parameter int ADDR_W = 12
);
   logic              byte_valid;
   logic              byte_ready;
   logic [7:0]        byte_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/imem_word_packer.sv
// Packs bytes MSB-first into 32-bit words with a one-cycle word-complete pulse.
// Latency: word_vld/word_dat registered one cycle after the 4th byte.
// No backpressure: every byte_vld is consumed; word_dat holds until the next word.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        byte_vld,
   input  logic [7:0]  byte_dat,
   output logic        word_last,
   output logic        word_vld,
   output logic [31:0] word_dat
);

   localparam int CNT_W = $clog2(BYTES_PER_WORD);
   localparam int ACC_W = (BYTES_PER_WORD - 1) * 8;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [31:0]      word_q, word_d;
   logic             vld_q, vld_d;

   assign word_last = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
   assign word_vld  = vld_q;
   assign word_dat  = word_q;

   always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      word_d = word_q;
      vld_d  = 1'b0;
      if (clr) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (byte_vld) begin
         acc_d = {acc_q[ACC_W-9:0], byte_dat};
         cnt_d = cnt_q + CNT_W'(1);
         // Separate output register so the next word can start filling during wr_en.
         if (word_last) begin
            word_d = {acc_q, byte_dat};
            vld_d  = 1'b1;
            cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         word_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         word_q <= word_d;
         vld_q  <= vld_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
// Latency: one memory write the cycle after each word's 4th byte; status registered.
// byte_ready high only while a header/data/checksum byte is expected; never stalls mid-load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MAX_WORDS = 4096,
   parameter int ADDR_W    = 12
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   imem_loader_if.slave    bus,
   output logic            cpu_hold,
   output logic            done,
   output logic            error,
   output logic [ADDR_W:0] word_count
);

   state_t            state_q, state_d;
   logic [HDR_W-1:0]  n_q, n_d;
   logic [ADDR_W:0]   wc_q, wc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rdy_q, rdy_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   logic              xfer, restart, pk_last, pk_vld;
   logic [31:0]       pk_dat;
   logic [HDR_W-1:0]  wc_inc;

   assign xfer    = bus.byte_valid & rdy_q;
   assign restart = start & ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
   assign wc_inc  = HDR_W'(wc_q) + HDR_W'(1);

   imem_word_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (restart),
      .byte_vld  (xfer && (state_q == ST_LOAD)),
      .byte_dat  (bus.byte_data),
      .word_last (pk_last),
      .word_vld  (pk_vld),
      .word_dat  (pk_dat)
   );

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      wc_d    = wc_q;
      addr_d  = addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      if (restart) begin
         state_d = ST_HDR0;
         wc_d    = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_d  = '0;
`endif
      end else if (xfer) begin
         case (state_q)
            ST_HDR0: begin
               n_d     = {bus.byte_data, n_q[7:0]};
               state_d = ST_HDR1;
            end
            ST_HDR1: begin
               n_d     = {n_q[HDR_W-1:8], bus.byte_data};
               state_d = hdr_ok(n_d, MAX_WORDS) ? ST_LOAD : ST_ERR;
            end
            ST_LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ bus.byte_data;
`endif
               // Count and address advance with the byte that completes a word.
               if (pk_last) begin
                  addr_d = wc_q[ADDR_W-1:0];
                  wc_d   = wc_q + (ADDR_W+1)'(1);
                  if (wc_inc == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_d = ST_CSUM;
`else
                     state_d = ST_DONE;
`endif
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: state_d = (bus.byte_data == csum_q) ? ST_DONE : ST_ERR;
`endif
            default: state_d = state_q;
         endcase
      end

      rdy_d  = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR));
      done_d = (state_d == ST_DONE);
      err_d  = (state_d == ST_ERR);
      hold_d = (state_d != ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         wc_q    <= '0;
         addr_q  <= '0;
         rdy_q   <= 1'b0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         wc_q    <= wc_d;
         addr_q  <= addr_d;
         rdy_q   <= rdy_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign bus.byte_ready = rdy_q;
   assign bus.wr_en      = pk_vld;
   assign bus.wr_addr    = addr_q;
   assign bus.wr_data    = pk_dat;
   assign cpu_hold       = hold_q;
   assign done           = done_q;
   assign error          = err_q;
   assign word_count     = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a byte-count reference model predicts every output each cycle.
// Directed sessions pin known words, header errors, checksum, gaps, reset and restart behaviour.
// Inputs change 1ns after posedge; outputs are compared on negedge.
module tb_imem_loader;

   localparam int MAXW = 4096;
   localparam int AW   = 12;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          cpu_hold, done, error;
   logic [AW:0]   word_count;

   imem_loader_if #(.ADDR_W(AW)) bus ();

   imem_loader #(.MAX_WORDS(MAXW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .bus        (bus),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: a session is a count of accepted bytes interpreted by position.
   bit          m_active, m_done, m_err, m_wr;
   int          m_acc, m_n, m_wc, m_pcnt, m_wr_addr;
   logic [7:0]  m_xor;
   logic [31:0] m_part, m_wr_data;

   logic [31:0] dut_mem [16];
   int          sess_wr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_done = 0; m_err = 0; m_wr = 0;
      m_acc = 0; m_n = 0; m_wc = 0; m_pcnt = 0; m_wr_addr = 0;
      m_xor = '0; m_part = '0; m_wr_data = '0;
   endtask

   task automatic model_step();
      logic [7:0] b;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_wr = 0;
      if (!m_active) begin
         if (start) begin
            m_active = 1; m_done = 0; m_err = 0;
            m_acc = 0; m_n = 0; m_wc = 0; m_pcnt = 0; m_xor = '0;
         end
      end else if (bus.byte_valid) begin
         b = bus.byte_data;
         if (m_acc == 0) begin
            m_n = int'(b) * 256;
         end else if (m_acc == 1) begin
            m_n = m_n + int'(b);
            if (m_n == 0 || m_n > MAXW) begin m_active = 0; m_err = 1; end
         end else if (m_acc < 2 + 4 * m_n) begin
            m_xor  = m_xor ^ b;
            m_part = {m_part[23:0], b};
            m_pcnt++;
            if (m_pcnt == 4) begin
               m_wr = 1; m_wr_addr = m_wc; m_wr_data = m_part;
               m_wc++; m_pcnt = 0;
               if (m_wc == m_n && CS == 0) begin m_active = 0; m_done = 1; end
            end
         end else begin
            m_active = 0;
            if (b == m_xor) m_done = 1; else m_err = 1;
         end
         m_acc++;
      end
   endtask

   task automatic compare();
      chk("byte_ready", {31'd0, bus.byte_ready}, {31'd0, m_active});
      chk("cpu_hold",   {31'd0, cpu_hold},       {31'd0, !m_done});
      chk("done",       {31'd0, done},           {31'd0, m_done});
      chk("error",      {31'd0, error},          {31'd0, m_err});
      chk("word_count", 32'(word_count),         32'(m_wc));
      chk("wr_en",      {31'd0, bus.wr_en},      {31'd0, m_wr});
      if (m_wr) begin
         chk("wr_addr", 32'(bus.wr_addr), 32'(m_wr_addr));
         chk("wr_data", bus.wr_data, m_wr_data);
      end
      if (bus.wr_en === 1'b1) begin
         sess_wr++;
         if (bus.wr_addr < 16) dut_mem[bus.wr_addr[3:0]] = bus.wr_data;
      end
   endtask

   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.byte_valid = 1'b0;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic begin_session();
      foreach (dut_mem[i]) dut_mem[i] = '0;
      sess_wr = 0;
      pulse_start();
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int   g;
      int   t;
      logic r;
      g = 0;
      t = 0;
      while (gap > 0 && $urandom_range(0, 99) < gap && g < 8) begin
         bus.byte_valid = 1'b0;
         cyc(1);
         g++;
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      while (1) begin
         r = bus.byte_ready;
         cyc(1);
         t++;
         if (r) break;
         if (t >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: byte %h not accepted after %0d cycles, acceptance required", b, t);
            bus.byte_valid = 1'b0;
            break;
         end
      end
   endtask

   function automatic logic [7:0] xor_of(input logic [7:0] d[$]);
      logic [7:0] x;
      x = '0;
      foreach (d[i]) x = x ^ d[i];
      return x;
   endfunction

   function automatic logic [31:0] word_of(input logic [7:0] d[$], input int i);
      return {d[4*i], d[4*i+1], d[4*i+2], d[4*i+3]};
   endfunction

   task automatic session(input logic [15:0] n, input logic [7:0] d[$], input logic [7:0] cs, input int gap);
      begin_session();
      send(n[15:8], gap);
      send(n[7:0], gap);
      foreach (d[i]) send(d[i], gap);
      if (CS != 0 && d.size() > 0) send(cs, gap);
      bus.byte_valid = 1'b0;
      cyc(3);
   endtask

   logic [7:0] d[$];
   logic [7:0] none[$];

   initial begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = '0;
      sess_wr = 0;
      foreach (dut_mem[i]) dut_mem[i] = '0;
      model_reset();
      fork
         forever begin
            @(posedge clk or negedge rst_n);
            model_step();
         end
         forever begin
            @(negedge clk);
            compare();
         end
      join_none

      // Reset state
      cyc(3);
      chk("rst_cpu_hold",   {31'd0, cpu_hold},       32'd1);
      chk("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
      chk("rst_word_count", 32'(word_count),         32'd0);
      rst_n = 1'b1;
      cyc(2);

      // Two-word program from the known instruction stream
      d = {8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
      chk("model_pin_xor", {24'd0, xor_of(d)}, 32'h0000_00AC);
      session(16'h0002, d, 8'hAC, 0);
      chk("basic_w0",     dut_mem[0], 32'h2008_0005);
      chk("basic_w1",     dut_mem[1], 32'h8C09_0004);
      chk("basic_writes", 32'(sess_wr), 32'd2);
      chk("basic_done",   {31'd0, done},     32'd1);
      chk("basic_hold",   {31'd0, cpu_hold}, 32'd0);
      chk("model_pin_wc", 32'(m_wc), 32'd2);

      // Header errors: zero length and one word beyond capacity
      session(16'h0000, none, 8'h00, 0);
      chk("hdr0_error",  {31'd0, error},    32'd1);
      chk("hdr0_hold",   {31'd0, cpu_hold}, 32'd1);
      chk("hdr0_writes", 32'(sess_wr),      32'd0);
      session(16'h1001, none, 8'h00, 0);
      chk("hdrbig_error",  {31'd0, error},    32'd1);
      chk("hdrbig_hold",   {31'd0, cpu_hold}, 32'd1);
      chk("hdrbig_writes", 32'(sess_wr),      32'd0);

      // Single word, good and bad trailing checksum
      d = {8'h01, 8'h02, 8'h03, 8'h04};
      session(16'h0001, d, 8'h04, 0);
      chk("cs_good_word", dut_mem[0], 32'h0102_0304);
      chk("cs_good_done", {31'd0, done}, 32'd1);
      session(16'h0001, d, 8'h05, 0);
      chk("cs_bad_word", dut_mem[0], 32'h0102_0304);
      chk("cs_bad_done", {31'd0, done}, (CS != 0) ? 32'd0 : 32'd1);

      // Four random words, gap-free and then at 50% valid density
      d.delete();
      for (int i = 0; i < 16; i++) d.push_back(8'($urandom_range(0, 255)));
      for (int pass = 0; pass < 2; pass++) begin
         session(16'h0004, d, xor_of(d), pass * 50);
         for (int w = 0; w < 4; w++) chk($sformatf("gap%0d_w%0d", pass, w), dut_mem[w], word_of(d, w));
         chk("gap_done", {31'd0, done}, 32'd1);
      end

      // Reset after 6 data bytes abandons the session
      begin_session();
      send(8'h00, 0); send(8'h04, 0);
      for (int i = 0; i < 6; i++) send(8'(8'h10 + i), 0);
      bus.byte_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst6_wr_en", {31'd0, bus.wr_en}, 32'd0);
      chk("rst6_hold",  {31'd0, cpu_hold},  32'd1);
      cyc(2);
      rst_n = 1'b1;
      cyc(1);

      // Reset landing in the write cycle suppresses the strobe at once
      begin_session();
      send(8'h00, 0); send(8'h02, 0);
      for (int i = 0; i < 4; i++) send(8'(8'h30 + i), 0);
      chk("rstw_wr_before", {31'd0, bus.wr_en}, 32'd1);
      bus.byte_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rstw_wr_en", {31'd0, bus.wr_en}, 32'd0);
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      d = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
      session(16'h0001, d, xor_of(d), 0);
      chk("fresh_addr0",  dut_mem[0], 32'hAABB_CCDD);
      chk("fresh_writes", 32'(sess_wr), 32'd1);

      // start during LOAD is ignored; start in DONE restarts cleanly
      d = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      begin_session();
      send(8'h00, 0); send(8'h02, 0);
      for (int i = 0; i < 4; i++) send(d[i], 0);
      pulse_start();
      for (int i = 4; i < 8; i++) send(d[i], 0);
      if (CS != 0) send(xor_of(d), 0);
      bus.byte_valid = 1'b0;
      cyc(2);
      chk("ign_w0",   dut_mem[0], 32'h1122_3344);
      chk("ign_w1",   dut_mem[1], 32'h5566_7788);
      chk("ign_done", {31'd0, done}, 32'd1);
      pulse_start();
      chk("rs_word_count", 32'(word_count), 32'd0);
      chk("rs_done",       {31'd0, done},   32'd0);
      chk("rs_hold",       {31'd0, cpu_hold}, 32'd1);
      send(8'h00, 0); send(8'h01, 0);
      for (int i = 0; i < 4; i++) send(d[i], 0);
      if (CS != 0) send(xor_of(d[0:3]), 0);
      bus.byte_valid = 1'b0;
      cyc(2);
      chk("rs_final_done", {31'd0, done}, 32'd1);

      // Random sessions
      for (int s = 0; s < 20; s++) begin
         int         n, kind, gap;
         logic [7:0] cs;
         n    = $urandom_range(1, 5);
         kind = $urandom_range(0, 9);
         gap  = $urandom_range(0, 60);
         if (kind == 0) begin
            session(($urandom_range(0, 1) == 0) ? 16'h0000 : 16'(MAXW + 1), none, 8'h00, gap);
            chk("rand_hdr_error", {31'd0, error}, 32'd1);
         end else begin
            d.delete();
            for (int i = 0; i < 4 * n; i++) d.push_back(8'($urandom_range(0, 255)));
            cs = xor_of(d) ^ ((kind == 1) ? 8'h01 : 8'h00);
            session(16'(n), d, cs, gap);
            chk("rand_done", {31'd0, done}, (CS == 0 || kind != 1) ? 32'd1 : 32'd0);
            for (int w = 0; w < n; w++) chk("rand_word", dut_mem[w], word_of(d, w));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
